// File: rtl/audio_decimator.sv
// ---------------------------------------------------------------------------
// audio_decimator
//
// Stereo decimation stage between the ADC side and the DAC side of an audio
// codec controller. One left/right pair is popped per loop and folded into
// the current group of 2^RATIO_LOG2 pairs. At the end of each group the hold
// registers are reloaded. The held value is written back to the controller
// once per input pair, which makes the output a zero-order hold of the
// downsampled signal at the input rate.
//
// Build option:
//   DS_AVG_EN defined   : hold = boxcar average of the group
//                         (sum >>> RATIO_LOG2, floor toward -inf).
//   DS_AVG_EN undefined : hold = last sample of the group; no accumulators.
//
// Parameters:
//   DATA_W      sample width per channel (signed two's complement)
//   RATIO_LOG2  log2 of the decimation factor, 0..8 (0 = pass-through)
//
// Ports:
//   CLOCK_50                system clock, rising edge
//   reset                   asynchronous active-high reset
//   audio_in_available      controller has an input pair ready
//   left_channel_audio_in   left ADC sample
//   right_channel_audio_in  right ADC sample
//   read_audio_in           one-cycle pop strobe
//   audio_out_allowed       controller DAC FIFO can accept a pair
//   left_channel_audio_out  held decimated left value
//   right_channel_audio_out held decimated right value
//   write_audio_out         one-cycle push strobe
//   block_done              one-cycle pulse when the hold registers update
//
// Handshake: the controller presents a pair while audio_in_available=1 and
// the pair is consumed on the clock edge that ends the read_audio_in cycle.
// A pair is pushed on the edge that ends the write_audio_out cycle, which is
// only issued after audio_out_allowed=1 was seen. Strobes are registered, last
// exactly one cycle and are never asserted together.
// ---------------------------------------------------------------------------
module audio_decimator #(
  parameter int DATA_W     = 32,
  parameter int RATIO_LOG2 = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              audio_in_available,
  input  logic [DATA_W-1:0] left_channel_audio_in,
  input  logic [DATA_W-1:0] right_channel_audio_in,
  output logic              read_audio_in,
  input  logic              audio_out_allowed,
  output logic [DATA_W-1:0] left_channel_audio_out,
  output logic [DATA_W-1:0] right_channel_audio_out,
  output logic              write_audio_out,
  output logic              block_done
);

  // cnt needs at least one bit even in pass-through mode
  localparam int CNT_W = (RATIO_LOG2 > 0) ? RATIO_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << RATIO_LOG2) - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    ACC,
    WAIT_OUT,
    WRITE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] sample_l;
  logic [DATA_W-1:0] sample_r;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] next_l;
  logic [DATA_W-1:0] next_r;
  logic              group_end;

  assign group_end = (cnt == CNT_LAST);

`ifdef DS_AVG_EN
  localparam int ACC_W = DATA_W + RATIO_LOG2;

  logic signed [ACC_W-1:0] acc_l;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] sum_l;
  logic signed [ACC_W-1:0] sum_r;

  // The sized cast of a signed operand sign-extends the sample.
  always_comb begin
    sum_l = acc_l + ACC_W'($signed(sample_l));
    sum_r = acc_r + ACC_W'($signed(sample_r));
  end

  // Low DATA_W bits of (sum >>> RATIO_LOG2) are simply the slice above the
  // discarded fraction bits; dropping them is the floor toward -inf.
  assign next_l = sum_l[RATIO_LOG2 +: DATA_W];
  assign next_r = sum_r[RATIO_LOG2 +: DATA_W];

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      acc_l <= '0;
      acc_r <= '0;
    end else if (state == ACC) begin
      acc_l <= group_end ? '0 : sum_l;
      acc_r <= group_end ? '0 : sum_r;
    end
  end
`else
  assign next_l = sample_l;
  assign next_r = sample_r;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      sample_l        <= '0;
      sample_r        <= '0;
      hold_l          <= '0;
      hold_r          <= '0;
      read_audio_in   <= 1'b0;
      write_audio_out <= 1'b0;
      block_done      <= 1'b0;
    end else begin
      // strobes are single-cycle unless a transition below re-arms them
      read_audio_in   <= 1'b0;
      write_audio_out <= 1'b0;
      block_done      <= 1'b0;
      case (state)
        IDLE: begin
          if (audio_in_available) begin
            state         <= READ;
            read_audio_in <= 1'b1;
          end
        end
        READ: begin
          sample_l <= left_channel_audio_in;
          sample_r <= right_channel_audio_in;
          state    <= ACC;
        end
        ACC: begin
          if (group_end) begin
            hold_l     <= next_l;
            hold_r     <= next_r;
            cnt        <= '0;
            block_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
          state <= WAIT_OUT;
        end
        WAIT_OUT: begin
          if (audio_out_allowed) begin
            state           <= WRITE;
            write_audio_out <= 1'b1;
          end
        end
        WRITE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign left_channel_audio_out  = hold_l;
  assign right_channel_audio_out = hold_r;

endmodule

// File: tb/tb_audio_decimator.sv
// ---------------------------------------------------------------------------
// tb_audio_decimator
//
// Self-checking bench for audio_decimator (DATA_W=32, RATIO_LOG2=2).
// A reference model computes the held value for every pushed input pair;
// the expected write value and expected block_done are queued when the pair
// is driven and compared when the DUT issues its write strobe. Expectations
// follow the DS_AVG_EN build option.
// ---------------------------------------------------------------------------
module tb_audio_decimator;

  localparam int DATA_W     = 32;
  localparam int RATIO_LOG2 = 2;
  localparam int GROUP      = 1 << RATIO_LOG2;
  localparam int TMO        = 200;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              avail = 1'b0;
  logic [DATA_W-1:0] lin = '0;
  logic [DATA_W-1:0] rin = '0;
  logic              allowed = 1'b1;
  logic              read_audio_in;
  logic              write_audio_out;
  logic              block_done;
  logic [DATA_W-1:0] lout;
  logic [DATA_W-1:0] rout;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  audio_decimator #(.DATA_W(DATA_W), .RATIO_LOG2(RATIO_LOG2)) dut (
    .CLOCK_50               (clk),
    .reset                  (rst),
    .audio_in_available     (avail),
    .left_channel_audio_in  (lin),
    .right_channel_audio_in (rin),
    .read_audio_in          (read_audio_in),
    .audio_out_allowed      (allowed),
    .left_channel_audio_out (lout),
    .right_channel_audio_out(rout),
    .write_audio_out        (write_audio_out),
    .block_done             (block_done)
  );

  // ---------------- checking ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [DATA_W-1:0] exp_l_q[$];
  logic [DATA_W-1:0] exp_r_q[$];
  logic              exp_bd_q[$];

  longint            m_sum_l = 0;
  longint            m_sum_r = 0;
  int                m_cnt   = 0;
  logic [DATA_W-1:0] m_hold_l = '0;
  logic [DATA_W-1:0] m_hold_r = '0;

  task automatic model_reset();
    m_sum_l  = 0;
    m_sum_r  = 0;
    m_cnt    = 0;
    m_hold_l = '0;
    m_hold_r = '0;
    exp_l_q.delete();
    exp_r_q.delete();
    exp_bd_q.delete();
  endtask

  task automatic model_push(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    longint q_l;
    longint q_r;
    logic   bd;
    m_sum_l += longint'($signed(l));
    m_sum_r += longint'($signed(r));
    m_cnt++;
    bd = 1'b0;
    if (m_cnt == GROUP) begin
`ifdef DS_AVG_EN
      q_l = m_sum_l >>> RATIO_LOG2;
      q_r = m_sum_r >>> RATIO_LOG2;
`else
      q_l = longint'($signed(l));
      q_r = longint'($signed(r));
`endif
      m_hold_l = q_l[DATA_W-1:0];
      m_hold_r = q_r[DATA_W-1:0];
      m_sum_l  = 0;
      m_sum_r  = 0;
      m_cnt    = 0;
      bd       = 1'b1;
    end
    exp_l_q.push_back(m_hold_l);
    exp_r_q.push_back(m_hold_r);
    exp_bd_q.push_back(bd);
  endtask

  // ---------------- monitor ----------------
  int                rd_total    = 0;
  int                wr_total    = 0;
  int                bd_total    = 0;
  int                last_wr_cyc = -100;
  logic              prev_rd     = 1'b0;
  logic              prev_wr     = 1'b0;
  logic              bd_pending  = 1'b0;
  logic [DATA_W-1:0] prev_l      = '0;
  logic [DATA_W-1:0] prev_r      = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_rd    = 1'b0;
      prev_wr    = 1'b0;
      bd_pending = 1'b0;
      prev_l     = '0;
      prev_r     = '0;
    end else begin
      if (read_audio_in || write_audio_out)
        check("rd_wr_exclusive", read_audio_in && write_audio_out, 1'b0);
      if (read_audio_in) begin
        rd_total++;
        check("rd_single_cycle", prev_rd, 1'b0);
        check("rd_after_wr_gap", (cyc - last_wr_cyc) >= 2, 1'b1);
      end
      if (write_audio_out) begin
        wr_total++;
        last_wr_cyc = cyc;
        check("wr_single_cycle", prev_wr, 1'b0);
        if (exp_l_q.size() == 0) begin
          check("unexpected_write", 1'b1, 1'b0);
        end else begin
          check("wr_left",  lout,       exp_l_q.pop_front());
          check("wr_right", rout,       exp_r_q.pop_front());
          check("wr_bd",    bd_pending, exp_bd_q.pop_front());
        end
        bd_pending = 1'b0;
      end
      if (block_done) begin
        bd_total++;
        bd_pending = 1'b1;
      end
      if (lout !== prev_l || rout !== prev_r)
        check("hold_change_only_on_bd", block_done, 1'b1);
      prev_rd = read_audio_in;
      prev_wr = write_audio_out;
      prev_l  = lout;
      prev_r  = rout;
    end
  end

  // ---------------- driver tasks ----------------
  int t_av = 0;

  // Presents a pair, waits for its read strobe, drops availability after the
  // capture edge. Returns the cycle of the read strobe.
  task automatic send_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                           output int rd_cyc);
    bit ok;
    @(posedge clk);
    #1;
    avail = 1'b1;
    lin   = l;
    rin   = r;
    t_av  = cyc;
    model_push(l, r);
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (read_audio_in) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("read_timeout", 1'b0, 1'b1);
    rd_cyc = cyc;
    @(posedge clk);
    #1;
    avail = 1'b0;
  endtask

  task automatic wait_write(output int wr_cyc);
    bit ok;
    ok = 1'b0;
    wr_cyc = -1;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (write_audio_out) begin
        ok = 1'b1;
        wr_cyc = cyc;
        break;
      end
    end
    if (!ok) check("write_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_drain(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    int rc;
    int wc;
    send_pair(l, r, rc);
    wait_write(wc);
  endtask

  task automatic drain_queue();
    for (int i = 0; i < TMO && exp_l_q.size() != 0; i++) @(negedge clk);
    check("drain_queue_empty", exp_l_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rc;
    int rc2;
    int wc;
    int r0;
    int w0;
    int b0;
    int c0;
    logic [DATA_W-1:0] exp_v;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_read",  read_audio_in,   1'b0);
    check("rst_write", write_audio_out, 1'b0);
    check("rst_bd",    block_done,      1'b0);
    check("rst_left",  lout,            '0);
    check("rst_right", rout,            '0);

    // idle: no strobes
    r0 = rd_total; w0 = wr_total; b0 = bd_total;
    repeat (20) @(negedge clk);
    check("idle_reads",  rd_total - r0, 0);
    check("idle_writes", wr_total - w0, 0);
    check("idle_bd",     bd_total - b0, 0);
    check("idle_left",   lout, '0);

    // group 1: 4,8,12,16 / 0,0,0,100 with minimum-loop timing on the first pair
    b0 = bd_total;
    send_pair(32'd4, 32'd0, rc);
    check("t1_read_latency", rc - t_av, 1);
    wait_write(wc);
    check("t1_write_latency", wc - rc, 3);
    send_drain(32'd8,  32'd0);
    send_drain(32'd12, 32'd0);
    send_drain(32'd16, 32'd100);
    check("t1_bd_count", bd_total - b0, 1);
`ifdef DS_AVG_EN
    check("t1_left_final",  lout, 32'd10);
    check("t1_right_final", rout, 32'd25);
`else
    check("t1_left_final",  lout, 32'd16);
    check("t1_right_final", rout, 32'd100);
`endif

    // group 2: negative floor rounding
    send_drain(-32'sd1, 32'd7);
    send_drain(-32'sd2, 32'd7);
    send_drain(-32'sd3, 32'd7);
    send_drain(-32'sd4, 32'd7);
`ifdef DS_AVG_EN
    exp_v = 32'hffff_fffd;
`else
    exp_v = 32'hffff_fffc;
`endif
    check("t2_neg_floor", lout, exp_v);

    // group 3: max positive, no wrap
    for (int i = 0; i < GROUP; i++) send_drain(32'h7fff_ffff, 32'h8000_0000);
    check("t3_max_pos", lout, 32'h7fff_ffff);
    check("t3_max_neg", rout, 32'h8000_0000);

    // groups 4-5: random data, back-to-back reads
    send_pair($urandom(), $urandom(), rc);
    for (int i = 1; i < 2 * GROUP; i++) begin
      send_pair($urandom(), $urandom(), rc2);
      if (i == 1) check("t4_read_spacing", rc2 - rc, 5);
    end
    drain_queue();

    // back-pressure: one read, no write while allowed is low
    allowed = 1'b0;
    r0 = rd_total; w0 = wr_total;
    send_pair(32'd40, 32'd80, rc);
    repeat (50) @(posedge clk);
    #1;
    check("bp_one_read", rd_total - r0, 1);
    check("bp_no_write", wr_total - w0, 0);
    allowed = 1'b1;
    c0 = cyc;
    wait_write(wc);
    check("bp_write_latency", wc - c0, 1);
    for (int i = 1; i < GROUP; i++) send_drain(32'd40, 32'd80);
    check("bp_group_value", lout, 32'd40);

    // reset with a partial group in flight
    send_drain(32'd1000, 32'd1000);
    send_drain(32'd1000, 32'd1000);
    @(posedge clk);
    #1;
    avail = 1'b1;
    lin   = 32'd1000;
    rin   = 32'd1000;
    for (int i = 0; i < TMO && !read_audio_in; i++) @(negedge clk);
    check("rs_saw_read", read_audio_in, 1'b1);
    rst = 1'b1;
    #1;
    check("rs_read_drop", read_audio_in, 1'b0);
    check("rs_write_low", write_audio_out, 1'b0);
    check("rs_out_clear", lout, '0);
    avail = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send_drain(32'd4,  32'd0);
    send_drain(32'd8,  32'd0);
    send_drain(32'd12, 32'd0);
    send_drain(32'd16, 32'd100);
`ifdef DS_AVG_EN
    check("rs_group_value", lout, 32'd10);
`else
    check("rs_group_value", lout, 32'd16);
`endif

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_l_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests_run=%0d", tests_run);
    $fatal(1);
  end

endmodule
